// File: rtl/ysyx22041405_mem_resp.sv
// Single-outstanding memory responder: word-addressed storage with byte-enabled
// writes, a fixed request-to-response latency and a valid/ready response channel.
// Illegal accesses (misaligned or outside the window) still take the full latency
// but return resp_err with zero data and never touch storage.
module ysyx22041405_mem_resp #(
   parameter int unsigned      WIDTH   = 32,
   parameter int unsigned      DEPTH   = 1024,
   parameter logic [WIDTH-1:0] BASE    = WIDTH'(32'h8000_0000),
   parameter int unsigned      LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_addr,
   input  logic               req_we,
   input  logic [WIDTH-1:0]   req_wdata,
   input  logic [WIDTH/8-1:0] req_wmask,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [WIDTH-1:0]   resp_rdata,
   output logic               resp_err
);

   localparam int unsigned LANES = WIDTH / 8;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [WIDTH-1:0] offset;
   logic [WIDTH-1:0] index_full;
   logic [AW-1:0]    mem_idx;
   logic             legal;
   logic             accept;
   logic             wr_en;

   // Address decode: word index relative to BASE plus the legality test.
   // A sub-BASE address wraps to a huge index, but it is rejected explicitly too.
   assign offset     = req_addr - BASE;
   assign index_full = offset >> 2;
   assign mem_idx    = index_full[AW-1:0];
   assign legal      = (req_addr[1:0] == 2'b00) && (req_addr >= BASE) &&
                       (index_full < WIDTH'(DEPTH));

   // Requests are only taken in IDLE, and never while reset is held.
   assign req_ready  = (state_q == IDLE) && rst;
   assign accept     = req_valid && req_ready;
   assign wr_en      = accept && req_we && legal;

   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // Storage write at the accept edge; only enabled byte lanes change. No reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < LANES; i++) begin
            if (req_wmask[i]) begin
               mem[mem_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
            end
         end
      end
   end

   // State, latency counter and response register; reset aborts any transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: accept -> count down -> present response until taken.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY <= 1) ? RESP : WAIT;
               err_d   = !legal;
               rdata_d = (legal && !req_we) ? mem[mem_idx] : '0;
            end
         end
         WAIT: begin
            // The counter reaching 0 on this edge completes the latency.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = '0;
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            rdata_d = '0;
            err_d   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx22041405_mem_resp.sv
`timescale 1ns/1ps
module tb_ysyx22041405_mem_resp;

   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Main instance, LATENCY = 2.
   logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr, req_wdata, resp_rdata;
   logic [3:0]  req_wmask;

   // Second instance, LATENCY = 1, for the throughput test.
   logic        req_valid1, req_ready1, req_we1, resp_valid1, resp_ready1, resp_err1;
   logic [31:0] req_addr1, req_wdata1, resp_rdata1;
   logic [3:0]  req_wmask1;

   ysyx22041405_mem_resp #(.WIDTH(32), .DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   ysyx22041405_mem_resp #(.WIDTH(32), .DEPTH(1024), .BASE(32'h8000_0000), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
      .req_we(req_we1), .req_wdata(req_wdata1), .req_wmask(req_wmask1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1),
      .resp_rdata(resp_rdata1), .resp_err(resp_err1)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   exp_t sb_q[$];
   exp_t sb1_q[$];
   vec_t vecs[21];

   int checks = 0;
   int errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // One complete transaction on the main instance. With hold > 0 the response
   // is held off for that many cycles while a stray request is presented.
   task automatic transact(input vec_t v, input int idx);
      exp_t e, got;
      int   k;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = v.addr;
      req_we    = v.we;
      req_wdata = v.wdata;
      req_wmask = v.wmask;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check1("req_ready_idle", req_ready, 1'b1);
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (v.hold > 0) begin
         req_addr  = 32'h8000_0010;
         req_we    = 1'b1;
         req_wdata = 32'h0;
         req_wmask = 4'hF;
      end else begin
         req_valid = 1'b0;
      end
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (v.hold > 0) check1("req_ready_busy", req_ready, 1'b0);
      end while (!resp_valid && k < 20);
      check32("latency", 32'(k), 32'(LAT));
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries required 1");
         got.rdata = '0;
         got.err   = 1'b0;
      end else begin
         got = sb_q.pop_front();
      end
      check32("resp_rdata", resp_rdata, got.rdata);
      check1("resp_err", resp_err, got.err);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         check1("hold_valid", resp_valid, 1'b1);
         check32("hold_rdata", resp_rdata, got.rdata);
         check1("hold_err", resp_err, got.err);
         check1("hold_req_ready", req_ready, 1'b0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check1("post_valid", resp_valid, 1'b0);
      check32("post_rdata", resp_rdata, 32'h0);
      check1("post_err", resp_err, 1'b0);
      check1("post_req_ready", req_ready, 1'b1);
      $display("txn %0d addr=%h we=%0d wdata=%h mask=%h rdata=%h err=%0d lat=%0d",
               idx, v.addr, v.we, v.wdata, v.wmask, got.rdata, got.err, k);
   endtask

   // Accept a request, then pull reset low in WAIT (in_resp=0) or RESP (in_resp=1).
   task automatic abort_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic in_resp, input logic [31:0] resp_data);
      int k;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = addr;
      req_we    = we;
      req_wdata = wdata;
      req_wmask = 4'hF;
      check1("abort_req_ready", req_ready, 1'b1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (in_resp) begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!resp_valid && k < 20);
         check32("abort_latency", 32'(k), 32'(LAT));
         check32("abort_pre_rdata", resp_rdata, resp_data);
      end else begin
         @(negedge clk);
         check1("abort_in_wait", resp_valid, 1'b0);
      end
      #2;
      rst = 1'b0;
      #1;
      check1("abort_valid", resp_valid, 1'b0);
      check1("abort_ready", req_ready, 1'b0);
      check32("abort_rdata", resp_rdata, 32'h0);
      check1("abort_err", resp_err, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check1("release_ready", req_ready, 1'b1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check1("no_stale_valid", resp_valid, 1'b0);
      end
      $display("abort addr=%h we=%0d in_resp=%0d", addr, we, in_resp);
   endtask

   // Safety net so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e, got;
      int last, n_acc, n_resp;
      vec_t rv;

      vecs[0]  = '{32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0};
      vecs[1]  = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{32'h8000_0010, 1'b1, 32'h0000_00AA, 4'h1, 0, 32'h0,         1'b0};
      vecs[3]  = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_BEAA, 1'b0};
      vecs[4]  = '{32'h8000_0002, 1'b0, 32'h0,         4'h0, 0, 32'h0,         1'b1};
      vecs[5]  = '{32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 0, 32'h0,         1'b1};
      vecs[6]  = '{32'h8000_1000, 1'b0, 32'h0,         4'h0, 0, 32'h0,         1'b1};
      vecs[7]  = '{32'hFFFF_FFFC, 1'b0, 32'h0,         4'h0, 0, 32'h0,         1'b1};
      vecs[8]  = '{32'h8000_0012, 1'b1, 32'h1111_1111, 4'hF, 0, 32'h0,         1'b1};
      vecs[9]  = '{32'h8000_1000, 1'b1, 32'h1111_1111, 4'hF, 0, 32'h0,         1'b1};
      vecs[10] = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_BEAA, 1'b0};
      vecs[11] = '{32'h8000_0010, 1'b1, 32'h1234_5678, 4'h0, 0, 32'h0,         1'b0};
      vecs[12] = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_BEAA, 1'b0};
      vecs[13] = '{32'h8000_0FFC, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         1'b0};
      vecs[14] = '{32'h8000_0FFC, 1'b0, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b0};
      vecs[15] = '{32'h8000_0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 0, 32'h0,         1'b0};
      vecs[16] = '{32'h8000_0000, 1'b1, 32'h1122_3344, 4'h6, 0, 32'h0,         1'b0};
      vecs[17] = '{32'h8000_0000, 1'b0, 32'h0,         4'h0, 5, 32'hA522_33A5, 1'b0};
      vecs[18] = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_BEAA, 1'b0};
      vecs[19] = '{32'h8000_0001, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1};
      vecs[20] = '{32'h8000_0000, 1'b0, 32'h0,         4'h0, 0, 32'hA522_33A5, 1'b0};

      rst = 1'b0;
      req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; req_wmask = '0;
      resp_ready = 1'b0;
      req_valid1 = 1'b0; req_addr1 = '0; req_we1 = 1'b0; req_wdata1 = '0; req_wmask1 = '0;
      resp_ready1 = 1'b0;

      repeat (3) @(negedge clk);
      check1("rst_req_ready", req_ready, 1'b0);
      check1("rst_resp_valid", resp_valid, 1'b0);
      check32("rst_resp_rdata", resp_rdata, 32'h0);
      check1("rst_resp_err", resp_err, 1'b0);
      check1("rst_req_ready1", req_ready1, 1'b0);
      rst = 1'b1;
      #1;
      check1("first_req_ready", req_ready, 1'b1);
      check1("first_req_ready1", req_ready1, 1'b1);

      for (int i = 0; i < 21; i++) begin
         transact(vecs[i], i);
      end

      // Write aborted in WAIT stays committed; read aborted in RESP leaves nothing behind.
      abort_txn(32'h8000_0020, 1'b1, 32'h1357_9BDF, 1'b0, 32'h0);
      rv = '{32'h8000_0020, 1'b0, 32'h0, 4'h0, 0, 32'h1357_9BDF, 1'b0};
      transact(rv, 100);
      abort_txn(32'h8000_0010, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEAA);
      rv = '{32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 32'hDEAD_BEAA, 1'b0};
      transact(rv, 101);

      // Back-to-back traffic on the LATENCY = 1 instance: one accept every 2 cycles.
      last = -1; n_acc = 0; n_resp = 0;
      @(negedge clk);
      req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 32'h8000_0040;
      req_wdata1 = 32'h0BAD_F00D; req_wmask1 = 4'hF; resp_ready1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) @(negedge clk);
         if (resp_valid1) begin
            if (sb1_q.size() == 0) begin
               errors++;
               $display("FAIL tput_scoreboard_empty: got 0 entries required 1");
            end else begin
               got = sb1_q.pop_front();
               check32("tput_rdata", resp_rdata1, got.rdata);
               check1("tput_err", resp_err1, got.err);
               $display("tput resp cycle=%0d rdata=%h err=%0d", c, resp_rdata1, resp_err1);
            end
            n_resp++;
         end
         if (req_ready1) begin
            if (last >= 0) check32("accept_spacing", 32'(c - last), 32'd2);
            last = c;
            n_acc++;
            e.rdata = req_we1 ? 32'h0 : 32'h0BAD_F00D;
            e.err   = 1'b0;
            sb1_q.push_back(e);
            @(posedge clk);
            #1;
            req_we1 = 1'b0;
         end
      end
      req_valid1 = 1'b0;
      @(negedge clk);
      check1("tput_drained", resp_valid1, 1'b0);
      check32("tput_accepts", 32'(n_acc), 32'd10);
      check32("tput_responses", 32'(n_resp), 32'd10);
      check32("sb_empty", 32'(sb_q.size()), 32'd0);
      check32("sb1_empty", 32'(sb1_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
